// File: rtl/ahb_apb_bridge_pkg.sv
// Shared types and encodings for the AHB-Lite to APB bridge.
package ahb_apb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Byte lanes for a 32-bit APB write; reads carry no strobes.
  function automatic logic [3:0] calc_pstrb(input logic write, input logic [2:0] size,
                                            input logic [1:0] addr);
    logic [3:0] strb;
    strb = 4'h0;
    if (write) begin
      case (size)
        HSIZE_BYTE: strb = 4'b0001 << addr;
        HSIZE_HALF: strb = 4'b0011 << {addr[1], 1'b0};
        default:    strb = 4'hF;
      endcase
    end
    return strb;
  endfunction

endpackage

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite subordinate to APB requester bridge, one APB SETUP/ACCESS per AHB transfer.
// Define AHB_APB_BRIDGE_TIMEOUT_EN to bound ACCESS at TIMEOUT cycles with a forced ERROR.
module ahb_apb_bridge
  import ahb_apb_bridge_pkg::*;
#(
  parameter int unsigned ADDR    = 24,
  parameter int unsigned PADDR   = 8,
  parameter int unsigned DATA    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hburst,
  input  logic [2:0]        hsize,
  input  logic [3:0]        hprot,
  input  logic              hmastlock,
  input  logic [ADDR-1:0]   haddr,
  input  logic              hwrite,
  input  logic [DATA-1:0]   hwdata,
  input  logic              hready,
  output logic [DATA-1:0]   hrdata,
  output logic              hresp,
  output logic              hreadyout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [2:0]        pprot,
  output logic [PADDR-1:0]  paddr,
  output logic [DATA-1:0]   pwdata,
  output logic [3:0]        pstrb,
  input  logic [DATA-1:0]   prdata,
  input  logic              pslverr,
  input  logic              pready
);

  state_e            state_q, state_d;
  logic              hreadyout_d, hresp_d, psel_d, penable_d, pwrite_d;
  logic [DATA-1:0]   hrdata_d, pwdata_d;
  logic [2:0]        pprot_d;
  logic [PADDR-1:0]  paddr_d;
  logic [3:0]        pstrb_d;
  logic              accept;
  logic              tmo_hit;

  logic unused_inputs;
  assign unused_inputs = ^{hburst, hmastlock, haddr[ADDR-1:PADDR], hprot[3:2]};

  assign accept = hsel & hready & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));

`ifdef AHB_APB_BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Counts ACCESS cycles; hit fires in the TIMEOUT-th ACCESS cycle without pready.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n)                tmo_cnt <= '0;
    else if (state_q == ST_SETUP) tmo_cnt <= '0;
    else if (state_q == ST_ACCESS) tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 32'd0);
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q   <= ST_IDLE;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      pprot     <= '0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
    end else begin
      state_q   <= state_d;
      hreadyout <= hreadyout_d;
      hresp     <= hresp_d;
      hrdata    <= hrdata_d;
      psel      <= psel_d;
      penable   <= penable_d;
      pwrite    <= pwrite_d;
      pprot     <= pprot_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      pstrb     <= pstrb_d;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    hreadyout_d = hreadyout;
    hresp_d     = hresp;
    hrdata_d    = hrdata;
    psel_d      = psel;
    penable_d   = penable;
    pwrite_d    = pwrite;
    pprot_d     = pprot;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    pstrb_d     = pstrb;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d     = ST_IDLE;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        if (accept) begin
          hreadyout_d = 1'b0;
          if (hsize > HSIZE_WORD) begin
            state_d = ST_ERR1;
            hresp_d = 1'b1;
          end else begin
            paddr_d  = haddr[PADDR-1:0];
            pwrite_d = hwrite;
            pprot_d  = {~hprot[0], 1'b0, hprot[1]};
            pstrb_d  = calc_pstrb(hwrite, hsize, haddr[1:0]);
            if (hwrite) begin
              state_d = ST_LATCH;
            end else begin
              state_d = ST_SETUP;
              psel_d  = 1'b1;
            end
          end
        end
      end
      ST_LATCH: begin
        pwdata_d = hwdata;
        psel_d   = 1'b1;
        state_d  = ST_SETUP;
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (pslverr) begin
            state_d = ST_ERR1;
            hresp_d = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            hreadyout_d = 1'b1;
            if (!pwrite) hrdata_d = prdata;
          end
        end else if (tmo_hit) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = ST_ERR1;
          hresp_d   = 1'b1;
        end
      end
      ST_ERR1: begin
        state_d     = ST_ERR2;
        hreadyout_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Scoreboard bench for ahb_apb_bridge: directed AHB vectors, APB completer model, decoupled monitors.
module tb_ahb_apb_bridge;
  import ahb_apb_bridge_pkg::*;

  logic        hclk = 1'b0;
  logic        hreset_n;
  logic        hsel, hwrite, hmastlock, hready;
  logic [1:0]  htrans;
  logic [2:0]  hburst, hsize;
  logic [3:0]  hprot;
  logic [23:0] haddr;
  logic [31:0] hwdata, hrdata, pwdata, prdata;
  logic        hresp, hreadyout, psel, penable, pwrite, pslverr, pready;
  logic [2:0]  pprot;
  logic [7:0]  paddr;
  logic [3:0]  pstrb;

  always #5 hclk = ~hclk;
  assign hready = hreadyout;

  ahb_apb_bridge #(.ADDR(24), .PADDR(8), .DATA(32), .TIMEOUT(4)) dut (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel), .htrans(htrans), .hburst(hburst),
    .hsize(hsize), .hprot(hprot), .hmastlock(hmastlock), .haddr(haddr), .hwrite(hwrite),
    .hwdata(hwdata), .hready(hready), .hrdata(hrdata), .hresp(hresp), .hreadyout(hreadyout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .pprot(pprot), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pslverr(pslverr), .pready(pready)
  );

  typedef struct {
    logic [23:0] addr; logic write; logic [2:0] size; logic [3:0] prot; logic [31:0] wdata;
    int apb_waits; logic [31:0] prdata; logic slverr; logic acc; logic cmp;
    logic e_resp; int e_waits; logic [3:0] e_strb; logic [2:0] e_prot; int gap;
  } vec_t;
  typedef struct { logic resp; logic is_read; logic [31:0] rdata; int waits; } ahb_exp_t;
  typedef struct { logic [7:0] addr; logic write; logic [3:0] strb; logic [31:0] wdata; logic [2:0] prot; } apb_exp_t;
  typedef struct { int waits; logic [31:0] rdata; logic err; } apb_rsp_t;

  ahb_exp_t ahb_q[$];
  apb_exp_t apb_q[$];
  apb_rsp_t rsp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one address phase, hold it until accepted, then drive its data phase.
  task automatic issue(input vec_t v);
    int guard;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = v.addr; hwrite = v.write;
    hsize = v.size; hprot = v.prot;
    ahb_q.push_back('{v.e_resp, !v.write && !v.e_resp, v.prdata, v.e_waits});
    if (v.cmp) apb_q.push_back('{v.addr[7:0], v.write, v.e_strb, v.wdata, v.e_prot});
    if (v.acc) rsp_q.push_back('{v.apb_waits, v.prdata, v.slverr});
    guard = 0;
    @(negedge hclk);
    while (!hready && guard < 100) begin
      guard++;
      @(negedge hclk);
    end
    if (guard >= 100) chk("addr_accept_bound", 32'(guard), 32'd0);
    @(posedge hclk); #1;
    hwdata = v.wdata;
    htrans = HTRANS_IDLE;
    repeat (v.gap) begin
      @(posedge hclk); #1;
    end
  endtask

  bit   dphase = 1'b0;
  int   wcnt = 0;
  logic last_resp = 1'b0;

  // AHB monitor: scores every data phase when hreadyout closes it.
  always @(negedge hclk) begin
    if (!hreset_n) begin
      dphase = 1'b0;
    end else begin
      if (dphase) begin
        if (hreadyout) begin
          if (ahb_q.size() == 0) begin
            chk("ahb_unexpected_completion", 32'd1, 32'd0);
          end else begin
            ahb_exp_t e;
            e = ahb_q.pop_front();
            chk("hresp", 32'(hresp), 32'(e.resp));
            chk("wait_states", 32'(wcnt), 32'(e.waits));
            if (e.is_read) chk("hrdata", hrdata, e.rdata);
            if (e.resp) chk("err_first_cycle_hresp", 32'(last_resp), 32'd1);
          end
          dphase = 1'b0;
        end else begin
          wcnt++;
          last_resp = hresp;
        end
      end
      if (hsel && hready && htrans[1]) begin
        dphase = 1'b1;
        wcnt = 0;
      end
    end
  end

  // APB monitor: scores each completed ACCESS.
  always @(negedge hclk) begin
    if (hreset_n && psel && penable && pready) begin
      if (apb_q.size() == 0) begin
        chk("apb_unexpected_access", 32'd1, 32'd0);
      end else begin
        apb_exp_t a;
        a = apb_q.pop_front();
        chk("paddr", 32'(paddr), 32'(a.addr));
        chk("pwrite", 32'(pwrite), 32'(a.write));
        chk("pstrb", 32'(pstrb), 32'(a.strb));
        chk("pprot", 32'(pprot), 32'(a.prot));
        if (a.write) chk("pwdata", pwdata, a.wdata);
      end
    end
  end

  // APB completer: pready high outside ACCESS (must be ignored), programmed waits inside.
  initial begin
    apb_rsp_t cur;
    bit active;
    int w;
    active = 1'b0; w = 0; cur = '{0, 32'h0, 1'b0};
    pready = 1'b1; pslverr = 1'b0; prdata = 32'h0;
    forever begin
      @(posedge hclk); #1;
      if (hreset_n && psel && penable) begin
        if (!active) begin
          if (rsp_q.size() == 0) chk("apb_rsp_available", 32'd0, 32'd1);
          else cur = rsp_q.pop_front();
          active = 1'b1;
          w = 0;
        end
        pready  = (w == cur.waits);
        prdata  = cur.rdata;
        pslverr = cur.err;
        w++;
      end else begin
        active  = 1'b0;
        pready  = 1'b1;
        pslverr = 1'b0;
      end
    end
  end

  task automatic drain();
    int guard;
    guard = 0;
    @(negedge hclk);
    while ((ahb_q.size() != 0 || dphase) && guard < 300) begin
      guard++;
      @(negedge hclk);
    end
    if (guard >= 300) chk("drain_bound", 32'(guard), 32'd0);
    @(posedge hclk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t vecs[10];
  vec_t v;

  initial begin
    vecs[0] = '{24'h000010, 1'b1, 3'd2, 4'h3, 32'hDEADBEEF, 0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 3, 4'hF, 3'b001, 2};
    vecs[1] = '{24'h000013, 1'b0, 3'd0, 4'h0, 32'h0,        2, 32'h11223344, 1'b0, 1'b1, 1'b1, 1'b0, 4, 4'h0, 3'b100, 1};
    vecs[2] = '{24'h000006, 1'b1, 3'd1, 4'h2, 32'h12345678, 0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 3, 4'hC, 3'b101, 0};
    vecs[3] = '{24'h000020, 1'b0, 3'd3, 4'h3, 32'h0,        0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1, 4'h0, 3'b001, 0};
    vecs[4] = '{24'h000024, 1'b0, 3'd2, 4'h3, 32'h0,        0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 3, 4'h0, 3'b001, 2};
    vecs[5] = '{24'h000030, 1'b0, 3'd2, 4'h3, 32'h0,        0, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b1, 1'b0, 2, 4'h0, 3'b001, 0};
    vecs[6] = '{24'h000034, 1'b0, 3'd2, 4'h3, 32'h0,        1, 32'h5A5A0001, 1'b0, 1'b1, 1'b1, 1'b0, 3, 4'h0, 3'b001, 0};
    vecs[7] = '{24'h0001F1, 1'b1, 3'd0, 4'h1, 32'h0000AB00, 0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 3, 4'h2, 3'b000, 0};
    vecs[8] = '{24'h00002A, 1'b0, 3'd1, 4'h3, 32'h0,        0, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1, 1'b0, 2, 4'h0, 3'b001, 1};
    vecs[9] = '{24'h00002E, 1'b1, 3'd3, 4'h3, 32'hFFFFFFFF, 0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1, 4'h0, 3'b001, 3};

    hreset_n = 1'b0; hsel = 1'b0; htrans = HTRANS_IDLE; hburst = 3'd0; hsize = 3'd0;
    hprot = 4'h0; hmastlock = 1'b0; haddr = 24'h0; hwrite = 1'b0; hwdata = 32'h0;
    #12;
    chk("rst_hreadyout", 32'(hreadyout), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_apb_ctrl", 32'({psel, penable, pwrite}), 32'd0);
    chk("rst_apb_data", 32'({paddr, pstrb, pprot}) | pwdata, 32'd0);
    @(posedge hclk); #2;
    hreset_n = 1'b1;
    @(posedge hclk); #1;

    foreach (vecs[i]) issue(vecs[i]);
    drain();

    // BUSY transfer: zero-wait OKAY and nothing forwarded.
    hsel = 1'b1; htrans = HTRANS_BUSY;
    @(posedge hclk); #1;
    htrans = HTRANS_IDLE;
    @(negedge hclk);
    chk("busy_hreadyout", 32'(hreadyout), 32'd1);
    chk("busy_hresp", 32'(hresp), 32'd0);
    chk("busy_psel", 32'(psel), 32'd0);
    @(posedge hclk); #1;

    // Asynchronous reset in the middle of a long ACCESS.
    v = '{24'h000040, 1'b0, 3'd2, 4'h3, 32'h0, 50, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 4'h0, 3'b001, 0};
    issue(v);
    begin
      int guard;
      guard = 0;
      @(negedge hclk);
      while (!(psel && penable) && guard < 20) begin
        guard++;
        @(negedge hclk);
      end
      chk("reach_access", 32'(psel && penable), 32'd1);
    end
    #2;
    hreset_n = 1'b0;
    #1;
    chk("midrst_psel", 32'(psel), 32'd0);
    chk("midrst_penable", 32'(penable), 32'd0);
    chk("midrst_hreadyout", 32'(hreadyout), 32'd1);
    chk("midrst_paddr", 32'(paddr), 32'd0);
    ahb_q.delete(); apb_q.delete(); rsp_q.delete();
    repeat (2) @(posedge hclk);
    #2;
    hreset_n = 1'b1;
    @(posedge hclk); #1;

    // Recovery read after reset.
    v = '{24'h000044, 1'b0, 3'd2, 4'h3, 32'h0, 0, 32'h01020304, 1'b0, 1'b1, 1'b1, 1'b0, 2, 4'h0, 3'b001, 1};
    issue(v);
    drain();

`ifdef AHB_APB_BRIDGE_TIMEOUT_EN
    // pready never rises: forced ERROR after four ACCESS cycles.
    v = '{24'h000050, 1'b0, 3'd2, 4'h3, 32'h0, 1000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 6, 4'h0, 3'b001, 1};
    issue(v);
    drain();
    chk("timeout_psel_low", 32'(psel), 32'd0);
    rsp_q.delete();
`endif

    repeat (3) @(posedge hclk);
    #1;
    chk("ahb_queue_empty", 32'(ahb_q.size()), 32'd0);
    chk("apb_queue_empty", 32'(apb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ahb_apb_bridge.md
# ahb_apb_bridge

AHB-Lite subordinate to APB requester bridge. It terminates the peripheral-side AHB port of the processor subsystem and drives a single APB completer, such as the DMA register block. Every accepted AHB transfer becomes exactly one APB SETUP/ACCESS pair. Wait states are inserted on AHB until the APB access finishes.

## Interface
- Reset is asynchronous, active-low (`hreset_n`); all logic is clocked by `hclk`.
- `ADDR`, default 24: AHB `haddr` width.
- `PADDR`, default 8: APB `paddr` width; equals `haddr[PADDR-1:0]`.
- `DATA`, default 32: data width (only 32 supported).
- `TIMEOUT`, default 255: maximum ACCESS cycles before a forced error (see Configuration).
- `hclk` in 1 — clock.
- `hreset_n` in 1 — asynchronous active-low reset.
- `hsel`, `htrans[1:0]`, `hburst[2:0]`, `hsize[2:0]`, `hprot[3:0]`, `hmastlock`, `haddr[ADDR]`, `hwrite`, `hwdata[DATA]`, `hready` — in, standard AHB-Lite subordinate inputs. `hburst` and `hmastlock` are ignored.
- `hrdata` out DATA; `hresp` out 1; `hreadyout` out 1 — AHB subordinate outputs.
- `psel`, `penable`, `pwrite` out 1; `pprot` out 3; `paddr` out PADDR; `pwdata` out DATA; `pstrb` out 4 — APB requester outputs.
- `prdata` in DATA; `pslverr` in 1; `pready` in 1 — APB completer responses.

## Operation
- Accept condition: `hsel & hready & htrans[1]` (NONSEQ or SEQ) while state is IDLE or ERR2. Latch `haddr`, `hwrite`, `hsize` and `hprot`.
- IDLE and BUSY transfers get a zero-wait OKAY and are not forwarded.
- `hsize > 2` gives an ERROR response (ERR1 → ERR2) with no APB access.
- FSM states:
  - IDLE → LATCH for a write.
  - IDLE → SETUP for a read.
  - LATCH: capture `hwdata` into `pwdata` → SETUP.
  - SETUP: `psel=1`, `penable=0` → ACCESS.
  - ACCESS: `psel=1`, `penable=1`; hold until `pready`.
  - On `pready` with `pslverr=0` → IDLE, with `hreadyout` registered to 1 and `hrdata` registered from `prdata` on reads.
  - On `pready` with `pslverr=1` → ERR1.
  - ERR1: `hresp=1`, `hreadyout=0` → ERR2.
  - ERR2: `hresp=1`, `hreadyout=1` → IDLE, or accept a new transfer.
- `hreadyout=0` in LATCH, SETUP, ACCESS and ERR1.
- `pstrb`:
  - Reads: 0.
  - Byte writes: `1<<haddr[1:0]`.
  - Halfword writes: `4'b0011<<{haddr[1],1'b0}`.
  - Word writes: `4'hF`.
- `pprot = {~hprot[0], 1'b0, hprot[1]}`.
- APB outputs hold their values when returning to IDLE; `psel` and `penable` are 0.
- Reset values (asserted asynchronously, including mid-transfer):
  - `hreadyout=1`.
  - `hresp`, `hrdata`, `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `pstrb` and `pprot` all 0.
  - State IDLE.

## Timing
- All outputs are registered; no combinational path from AHB inputs to APB outputs.
- Read: address phase at cycle N; SETUP at N+1; ACCESS at N+2. With `pready=1` at N+2, `hreadyout=1` and valid `hrdata` appear at N+3. The read costs 2 AHB wait states plus one per APB wait.
- Write: LATCH at N+1, SETUP at N+2, ACCESS at N+3, `hreadyout=1` at N+4.
- A new transfer may be accepted in the completion cycle (back-to-back; no idle cycle required on AHB).
- `pready` during SETUP is ignored.

## Configuration
- `AHB_APB_BRIDGE_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TIMEOUT+1)` counts ACCESS cycles.
  - When it reaches `TIMEOUT` without `pready`, `psel` and `penable` drop next cycle and the FSM enters ERR1.
  - The counter clears on entry to SETUP.
- Not defined: ACCESS waits indefinitely. `TIMEOUT` is unused and no counter is built.

## Structure
- Package `ahb_apb_bridge_pkg` contains:
  - the state enum;
  - `htrans` encodings (IDLE, BUSY, NONSEQ, SEQ);
  - `hsize` encodings;
  - a `pstrb` computation function.
- Single module; no sub-module warranted.

## Test plan
- Word write to `0x000010`, `hwdata=0xDEADBEEF`, `pready=1` → `paddr=0x10`, `pwrite=1`, `pstrb=F`; `hreadyout` low for 3 cycles, OKAY.
- Byte read at `0x000013`, `prdata=0x11223344`, 2 APB wait cycles → `pstrb=0`; `hrdata=0x11223344` after 4 wait states.
- Halfword write at `0x000006` → `pstrb=4'b1100`. `hsize=3` → two-cycle ERROR with `psel` never asserted.
- `pslverr=1` on read → `hresp=1` with `hreadyout=0`, then `hresp=1` with `hreadyout=1`; then IDLE.
- `hreset_n` asserted during ACCESS → `psel=0`, `penable=0`, `hreadyout=1` immediately. With the macro and `TIMEOUT=4`, `pready` held low → error after 4 ACCESS cycles.
- Back-to-back reads with a NONSEQ in the completion cycle → second SETUP on the next cycle, no lost transfer.
